ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED
//  (set LEDs), 0xF4 (enable) or 0xFF (reset), using open-drain CLK/DATA control.
//  Counterpart of KBDecoder on the same PS/2 pins; runs in the CLK domain beside it.
//  BUSY lets the top level gate KBDecoder, so host-driven edges are not decoded as scan codes.
// PARAMETERS
//  INHIBIT_CYC  10000    cycles PS2 clock is held low before request-to-send (100 us @ 100 MHz)
//  TIMEOUT_CYC  2000000  max cycles from RTS release to line-idle before ERR (20 ms @ 100 MHz)
// PORTS
//  CLK        in   1  system clock; all logic on rising edge
//  RST        in   1  synchronous reset, active-high
//  TXDATA     in   8  byte to send; latched when TXSTART is accepted
//  TXSTART    in   1  1-cycle request; accepted only in IDLE
//  PS2CLK_IN  in   1  raw PS/2 clock pin level (asynchronous)
//  PS2DATA_IN in   1  raw PS/2 data pin level (asynchronous)
//  PS2CLK_OE  out  1  1 = pull PS/2 clock low; 0 = release (pad is open-drain)
//  PS2DATA_OE out  1  1 = pull PS/2 data low; 0 = release
//  BUSY       out  1  high from TXSTART acceptance until DONE/ERR cycle inclusive
//  DONE       out  1  1-cycle pulse: byte acknowledged and lines idle
//  ERR        out  1  1-cycle pulse: missing ACK or timeout; never coincident with DONE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, both lines released.
//  Inputs pass through a 2-flop synchronizer. fall = synced clock was 1 last cycle, is 0 now.
//  IDLE:    TXSTART=1 -> latch TXDATA and parity P = ~^TXDATA (odd parity).
//           Next cycle: INHIBIT, BUSY=1. TXSTART while BUSY is ignored, with no queueing.
//  INHIBIT: CLK_OE=1, DATA_OE=0 for exactly INHIBIT_CYC cycles.
//  START:   CLK_OE=1, DATA_OE=1 for 1 cycle (start bit 0 set up before release).
//  RTS:     CLK_OE=0, DATA_OE=1. Timeout counter cleared on entry.
//           Edge counter n=0; the device now clocks.
//  SHIFT:   on each fall, n increments. n=1..8 drive bit n-1 (LSB first), n=9 drive P,
//           n=10 release data (stop bit 1). Driving a 1 means DATA_OE=0; a 0 means DATA_OE=1.
//           Data changes only on the cycle after the fall is detected.
//  ACK:     on fall n=11, sample synced data. 0 -> WAITIDLE; 1 -> ERR pulse, then IDLE.
//  WAITIDLE: both synced lines high -> DONE pulse, then IDLE.
//  Timeout: counter runs in RTS/SHIFT/ACK/WAITIDLE.
//           At TIMEOUT_CYC -> ERR pulse, both OE=0, IDLE.
//  Counters: inhibit $clog2(INHIBIT_CYC+1) bits, timeout $clog2(TIMEOUT_CYC+1) bits,
//           edge 4 bits. All saturate/clear, never wrap.
//  RST mid-frame: next edge releases both lines and returns to IDLE; no DONE/ERR.
//  Falls detected in IDLE/INHIBIT/START are ignored.
//  DONE/ERR deassert BUSY the following cycle; TXSTART is accepted again on that cycle.
// STRUCTURE
//  Include ps2_defs.vh holds state encodings (IDLE, INHIBIT, START, RTS, SHIFT, ACK,
//  WAITIDLE), command constants (PS2_CMD_SETLED=8'hED, PS2_CMD_ENABLE=8'hF4,
//  PS2_CMD_RESET=8'hFF) and the ACK edge index (11).
//  Sub-module ps2_line_sync: 2-flop synchronizer with falling-edge detect, sync reset,
//  instantiated for CLK and DATA.
// TESTING
//  Device model clocks at 12.5 kHz, sampling data on the rising edge.
//  Reduce INHIBIT_CYC/TIMEOUT_CYC in the bench.
//  1 TXDATA=8'hED, TXSTART -> CLK_OE low INHIBIT_CYC cycles; model captures 0,10110111,P=1,stop=1;
//    model ACKs -> DONE once, BUSY falls the next cycle.
//  2 TXDATA=8'h01 -> parity bit 0; TXDATA=8'hFF -> parity bit 1. Both DONE.
//  3 Model withholds ACK (data high at edge 11) -> ERR pulse, no DONE, both OE=0.
//  4 Model never clocks after RTS -> ERR exactly TIMEOUT_CYC cycles after RTS entry; lines released.
//  5 Second TXSTART during SHIFT -> ignored; transmitted byte unchanged; one DONE only.
//  6 RST asserted at edge 5 -> next cycle both OE=0, BUSY=0, no DONE/ERR;
//    new TXSTART then completes normally.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared state encoding, command bytes and frame edge indices for the PS/2 host transmitter.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INHIBIT  = 3'd1,
      ST_START    = 3'd2,
      ST_RTS      = 3'd3,
      ST_SHIFT    = 3'd4,
      ST_ACK      = 3'd5,
      ST_WAITIDLE = 3'd6
   } state_t;

   localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

   localparam logic [3:0] PARITY_EDGE = 4'd9;
   localparam logic [3:0] STOP_EDGE   = 4'd10;
   localparam logic [3:0] ACK_EDGE    = 4'd11;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin, with a falling-edge strobe on the synced level.
module ps2_line_sync (
   input  logic clk,
   input  logic srst,
   input  logic raw,
   output logic level,
   output logic fall
);
   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   // Reset to the idle-high bus level so leaving reset never fakes a fall.
   always_ff @(posedge clk) begin
      if (srst) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
         prev_reg <= 1'b1;
      end else begin
         meta_reg <= raw;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign level = sync_reg;
   assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte on device
// clock falls, check the device ACK and wait for an idle bus before reporting.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYC = 10000,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] TXDATA,
   input  logic       TXSTART,
   input  logic       PS2CLK_IN,
   input  logic       PS2DATA_IN,
   output logic       PS2CLK_OE,
   output logic       PS2DATA_OE,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);
   localparam int INH_W = $clog2(INHIBIT_CYC + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = {TO_W{1'b1}};
   localparam int LINE_CLK  = 0;
   localparam int LINE_DATA = 1;

   logic [1:0] line_raw;
   logic [1:0] line_level;
   logic [1:0] line_fall;
   logic       sync_unused;
   logic       clk_fall;
   logic       clk_level;
   logic       data_level;

   assign line_raw = {PS2DATA_IN, PS2CLK_IN};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         ps2_line_sync u_sync (
            .clk   (CLK),
            .srst  (RST),
            .raw   (line_raw[gi]),
            .level (line_level[gi]),
            .fall  (line_fall[gi])
         );
      end
   endgenerate

   // Only the clock line's edges pace the frame; data is read as a level.
   assign sync_unused = line_fall[LINE_DATA];
   assign clk_fall    = line_fall[LINE_CLK];
   assign clk_level   = line_level[LINE_CLK];
   assign data_level  = line_level[LINE_DATA];

   state_t           state_reg, state_next;
   logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
   logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
   logic [3:0]       edge_cnt_reg, edge_cnt_next;
   logic [3:0]       edge_inc;
   logic [7:0]       data_reg, data_next;
   logic             parity_reg, parity_next;
   logic             clk_oe_reg, clk_oe_next;
   logic             data_oe_reg, data_oe_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             err_reg, err_next;
   logic             timed;

   assign edge_inc = (edge_cnt_reg == 4'hF) ? 4'hF : edge_cnt_reg + 4'd1;
   assign timed    = (state_reg == ST_RTS) || (state_reg == ST_SHIFT) ||
                     (state_reg == ST_ACK) || (state_reg == ST_WAITIDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= ST_IDLE;
         inh_cnt_reg  <= '0;
         to_cnt_reg   <= '0;
         edge_cnt_reg <= '0;
         data_reg     <= '0;
         parity_reg   <= 1'b0;
         clk_oe_reg   <= 1'b0;
         data_oe_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         inh_cnt_reg  <= inh_cnt_next;
         to_cnt_reg   <= to_cnt_next;
         edge_cnt_reg <= edge_cnt_next;
         data_reg     <= data_next;
         parity_reg   <= parity_next;
         clk_oe_reg   <= clk_oe_next;
         data_oe_reg  <= data_oe_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      inh_cnt_next  = inh_cnt_reg;
      to_cnt_next   = to_cnt_reg;
      edge_cnt_next = edge_cnt_reg;
      data_next     = data_reg;
      parity_next   = parity_reg;
      done_next     = 1'b0;
      err_next      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // busy_reg is still set during the DONE/ERR cycle, which blocks a restart there.
            if (TXSTART && !busy_reg) begin
               data_next    = TXDATA;
               parity_next  = odd_parity(TXDATA);
               inh_cnt_next = '0;
               state_next   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt_reg == INH_LAST) state_next = ST_START;
            else                         inh_cnt_next = inh_cnt_reg + 1'b1;
         end
         ST_START: begin
            to_cnt_next   = '0;
            edge_cnt_next = '0;
            state_next    = ST_RTS;
         end
         ST_RTS: begin
            if (clk_fall) begin
               edge_cnt_next = edge_inc;
               state_next    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (clk_fall) begin
               edge_cnt_next = edge_inc;
               if (edge_inc == STOP_EDGE) state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               edge_cnt_next = ACK_EDGE;
               if (!data_level) begin
                  state_next = ST_WAITIDLE;
               end else begin
                  err_next   = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         end
         ST_WAITIDLE: begin
            if (clk_level && data_level) begin
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // The timeout overrides any progress made in the same cycle.
      if (timed) begin
         if (to_cnt_reg != TO_MAX) to_cnt_next = to_cnt_reg + 1'b1;
         if (to_cnt_reg >= TO_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b0;
            err_next   = 1'b1;
         end
      end

      // Pad enables are decoded from the next state so they leave a flop glitch-free.
      clk_oe_next = (state_next == ST_INHIBIT) || (state_next == ST_START);
      case (state_next)
         ST_START, ST_RTS: data_oe_next = 1'b1;
         ST_SHIFT: begin
            if (edge_cnt_next == PARITY_EDGE) data_oe_next = ~parity_next;
            else data_oe_next = ~data_next[3'(edge_cnt_next - 4'd1)];
         end
         default: data_oe_next = 1'b0;
      endcase

      busy_next = (state_next != ST_IDLE) || done_next || err_next;
   end

   assign PS2CLK_OE  = clk_oe_reg;
   assign PS2DATA_OE = data_oe_reg;
   assign BUSY       = busy_reg;
   assign DONE       = done_reg;
   assign ERR        = err_reg;

endmodule
